// File: rtl/bpuf_meas_pkg.sv
// rtl/bpuf_meas_pkg.sv - shared FSM encoding and default sizing for the RO pair measurement stage
package bpuf_meas_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_COUNT = 2'd2,
    ST_EVAL  = 2'd3
  } meas_state_e;

  localparam int DEF_CNT_W  = 16;
  localparam int DEF_RESP_W = 8;
  localparam int DEF_THRESH = 4;

endpackage

// File: rtl/meas_edge_cnt.sv
// rtl/meas_edge_cnt.sv - oscillator synchronizer, rising-edge detect and saturating edge counter
module meas_edge_cnt
  import bpuf_meas_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_osc,
  input  logic             i_clear,
  input  logic             i_enable,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_sat
);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  logic [CNT_W-1:0] r_cnt;
  logic             w_rise;
  logic             w_sat;

  // Synchronizer keeps running outside COUNT so no stale edge is seen when counting restarts
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_osc;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_rise = r_sync2 & ~r_prev;
  assign w_sat  = &r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && w_rise && !w_sat) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;
  assign o_sat = w_sat;

endmodule

// File: rtl/meas_pair_eval.sv
// rtl/meas_pair_eval.sv - windowed RO pair compare, bit/stability packing and valid/ready word output
module meas_pair_eval
  import bpuf_meas_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int RESP_W = DEF_RESP_W,
  parameter int THRESH = DEF_THRESH
) (
  input  logic              I_clk,
  input  logic              I_rst_n,
  input  logic              I_meas_rst,
  input  logic              I_osc_a,
  input  logic              I_osc_b,
  input  logic              I_resp_ready,
  output logic [RESP_W-1:0] O_resp,
  output logic [RESP_W-1:0] O_resp_mask,
  output logic              O_resp_valid,
  output logic              O_overrun,
  output logic              O_busy
);

  localparam int              FILL_W    = (RESP_W > 1) ? $clog2(RESP_W) : 1;
  localparam logic [FILL_W-1:0] LP_LAST = FILL_W'(RESP_W - 1);
  localparam logic [CNT_W:0]  LP_THRESH = (CNT_W + 1)'(THRESH);

  meas_state_e r_state;
  meas_state_e w_state_nxt;
  logic        w_cnt_clear;
  logic        w_cnt_en;
  logic        w_eval;

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Window level is used raw; control holds each phase for ~2^20 cycles
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clear = 1'b0;
    w_cnt_en    = 1'b0;
    w_eval      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (I_meas_rst) w_state_nxt = ST_ARM;
      end
      ST_ARM: begin
        if (!I_meas_rst) begin
          w_state_nxt = ST_COUNT;
          w_cnt_clear = 1'b1;
        end
      end
      ST_COUNT: begin
        w_cnt_en = !I_meas_rst;
        if (I_meas_rst) w_state_nxt = ST_EVAL;
      end
      ST_EVAL: begin
        w_eval      = 1'b1;
        w_state_nxt = ST_ARM;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  logic [CNT_W-1:0] w_cnt_a;
  logic [CNT_W-1:0] w_cnt_b;
  logic             w_sat_a;
  logic             w_sat_b;

  meas_edge_cnt #(.CNT_W(CNT_W)) u_cnt_a (
    .i_clk    (I_clk),
    .i_rst_n  (I_rst_n),
    .i_osc    (I_osc_a),
    .i_clear  (w_cnt_clear),
    .i_enable (w_cnt_en),
    .o_cnt    (w_cnt_a),
    .o_sat    (w_sat_a)
  );

  meas_edge_cnt #(.CNT_W(CNT_W)) u_cnt_b (
    .i_clk    (I_clk),
    .i_rst_n  (I_rst_n),
    .i_osc    (I_osc_b),
    .i_clear  (w_cnt_clear),
    .i_enable (w_cnt_en),
    .o_cnt    (w_cnt_b),
    .o_sat    (w_sat_b)
  );

  logic signed [CNT_W:0] w_diff;
  logic        [CNT_W:0] w_abs;
  logic                  w_bit;
  logic                  w_stable;

  // One extra bit keeps the difference exact for any pair of CNT_W counts
  assign w_diff   = $signed({1'b0, w_cnt_a}) - $signed({1'b0, w_cnt_b});
  assign w_abs    = w_diff[CNT_W] ? $unsigned(-w_diff) : $unsigned(w_diff);
  assign w_bit    = (w_cnt_a > w_cnt_b);
  assign w_stable = (w_abs >= LP_THRESH) && !w_sat_a && !w_sat_b;

  logic [FILL_W-1:0] r_fill;
  logic [RESP_W-1:0] r_bits;
  logic [RESP_W-1:0] r_mask;
  logic [RESP_W-1:0] w_word_bits;
  logic [RESP_W-1:0] w_word_mask;
  logic              w_last;
  logic              w_load;

  always_comb begin
    w_word_bits         = r_bits;
    w_word_mask         = r_mask;
    w_word_bits[r_fill] = w_bit;
    w_word_mask[r_fill] = w_stable;
  end

  assign w_last = (r_fill == LP_LAST);
  assign w_load = w_eval && w_last && (!O_resp_valid || I_resp_ready);

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      r_fill <= '0;
      r_bits <= '0;
      r_mask <= '0;
    end else if (w_eval) begin
      if (w_last) begin
        r_fill <= '0;
        r_bits <= '0;
        r_mask <= '0;
      end else begin
        r_fill <= r_fill + FILL_W'(1);
        r_bits <= w_word_bits;
        r_mask <= w_word_mask;
      end
    end
  end

  logic [RESP_W-1:0] r_resp;
  logic [RESP_W-1:0] r_resp_mask;
  logic              r_valid;
  logic              r_overrun;

  // A completing word may replace the held one only in the cycle it is being accepted
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      r_resp      <= '0;
      r_resp_mask <= '0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_load) begin
        r_resp      <= w_word_bits;
        r_resp_mask <= w_word_mask;
        r_valid     <= 1'b1;
      end else if (r_valid && I_resp_ready) begin
        r_valid <= 1'b0;
      end
      if (w_eval && w_last && !w_load) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign O_resp       = r_resp;
  assign O_resp_mask  = r_resp_mask;
  assign O_resp_valid = r_valid;
  assign O_overrun    = r_overrun;
  assign O_busy       = (r_state == ST_COUNT) || (r_state == ST_EVAL);

endmodule

// File: tb/tb_meas_pair_eval.sv
// tb/tb_meas_pair_eval.sv - scoreboard bench for meas_pair_eval, plus a 4-bit-counter instance for saturation
`timescale 1ns/1ps
module tb_meas_pair_eval;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       meas_rst;
  logic       resp_ready;
  logic       sat_ready = 1'b1;
  logic       osc_a_gen = 1'b0;
  logic       osc_b_gen = 1'b0;
  logic       tie_mode = 1'b0;
  logic       osc_a;
  logic       osc_b;
  int         hp_a = 40;
  int         hp_b = 50;

  logic [7:0] resp;
  logic [7:0] resp_mask;
  logic       resp_valid;
  logic       overrun;
  logic       busy;
  logic [0:0] sat_resp;
  logic [0:0] sat_mask;
  logic       sat_valid;
  logic       sat_overrun;
  logic       sat_busy;

  int errors = 0;
  int checks = 0;

  logic [15:0] sb[$];
  logic [1:0]  sb_sat[$];

  always #5 clk = ~clk;

  initial begin
    #3;
    forever begin
      #(hp_a);
      osc_a_gen = ~osc_a_gen;
    end
  end

  initial begin
    #3;
    forever begin
      #(hp_b);
      osc_b_gen = ~osc_b_gen;
    end
  end

  assign osc_a = osc_a_gen;
  assign osc_b = tie_mode ? osc_a_gen : osc_b_gen;

  meas_pair_eval dut (
    .I_clk        (clk),
    .I_rst_n      (rst_n),
    .I_meas_rst   (meas_rst),
    .I_osc_a      (osc_a),
    .I_osc_b      (osc_b),
    .I_resp_ready (resp_ready),
    .O_resp       (resp),
    .O_resp_mask  (resp_mask),
    .O_resp_valid (resp_valid),
    .O_overrun    (overrun),
    .O_busy       (busy)
  );

  meas_pair_eval #(.CNT_W(4), .RESP_W(1), .THRESH(4)) dut_sat (
    .I_clk        (clk),
    .I_rst_n      (rst_n),
    .I_meas_rst   (meas_rst),
    .I_osc_a      (osc_a),
    .I_osc_b      (osc_b),
    .I_resp_ready (sat_ready),
    .O_resp       (sat_resp),
    .O_resp_mask  (sat_mask),
    .O_resp_valid (sat_valid),
    .O_overrun    (sat_overrun),
    .O_busy       (sat_busy)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  // 0: A/4 B/5 cycles, 1: exact tie, 2: A/4 B/4.5, 3: A/2 B/20
  task automatic set_mode(input int m);
    case (m)
      0: begin tie_mode = 1'b0; hp_a = 40; hp_b = 50;  end
      1: begin tie_mode = 1'b1; hp_a = 40; hp_b = 50;  end
      2: begin tie_mode = 1'b0; hp_a = 40; hp_b = 45;  end
      default: begin tie_mode = 1'b0; hp_a = 20; hp_b = 200; end
    endcase
  endtask

  // Ends at the negedge inside the EVAL cycle
  task automatic window(input int m, input int low_cyc);
    set_mode(m);
    meas_rst = 1'b1;
    repeat (10) tick();
    meas_rst = 1'b0;
    repeat (low_cyc) tick();
    meas_rst = 1'b1;
    tick();
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    meas_rst   = 1'b1;
    resp_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    meas_rst   = 1'b1;
    resp_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    checks++;
    if ({resp, resp_mask} !== 16'h0000) begin
      errors++; $display("FAIL reset_word: got %h required 0000", {resp, resp_mask});
    end
    checks++;
    if ({resp_valid, overrun, busy} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b required 000", {resp_valid, overrun, busy});
    end
    tick();
  endtask

  task automatic test_basic();
    logic [15:0] exp;
    sb.push_back({8'hFF, 8'hFF});
    for (int w = 0; w < 8; w++) window(0, 200);
    checks++;
    if ({resp_valid, busy} !== 2'b01) begin
      errors++; $display("FAIL basic_in_eval: valid,busy=%b required 01", {resp_valid, busy});
    end
    tick();
    checks++;
    if (resp_valid !== 1'b1) begin
      errors++; $display("FAIL basic_valid_after_eval: got %b required 1", resp_valid);
    end
    exp = sb.pop_front();
    checks++;
    if ({resp, resp_mask} !== exp) begin
      errors++; $display("FAIL basic_word: got %h required %h", {resp, resp_mask}, exp);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL basic_valid_drop: got %b required 0", resp_valid);
    end
  endtask

  task automatic test_near_tie();
    logic [15:0] exp;
    sb.push_back({8'hF0, 8'h00});
    for (int w = 0; w < 4; w++) window(1, 200);
    for (int w = 0; w < 4; w++) window(2, 200);
    tick();
    exp = sb.pop_front();
    checks++;
    if ({resp_valid, resp, resp_mask} !== {1'b1, exp}) begin
      errors++; $display("FAIL near_tie_word: got %h required %h", {resp_valid, resp, resp_mask}, {1'b1, exp});
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [15:0] exp;
    sb.push_back({8'hFF, 8'hFF});
    for (int w = 0; w < 8; w++) window(0, 200);
    tick();
    exp = sb.pop_front();
    checks++;
    if ({resp_valid, overrun, resp, resp_mask} !== {2'b10, exp}) begin
      errors++; $display("FAIL bp_first_word: got %h required %h", {resp_valid, overrun, resp, resp_mask}, {2'b10, exp});
    end
    for (int w = 0; w < 8; w++) window(1, 200);
    tick();
    checks++;
    if ({resp, resp_mask} !== exp) begin
      errors++; $display("FAIL bp_retained: got %h required %h", {resp, resp_mask}, exp);
    end
    checks++;
    if ({resp_valid, overrun} !== 2'b11) begin
      errors++; $display("FAIL bp_overrun: valid,overrun=%b required 11", {resp_valid, overrun});
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL bp_one_transfer: valid=%b required 0", resp_valid);
    end
    repeat (5) tick();
    checks++;
    if ({resp_valid, overrun} !== 2'b01) begin
      errors++; $display("FAIL bp_after_transfer: valid,overrun=%b required 01", {resp_valid, overrun});
    end
  endtask

  task automatic test_reset_mid_window();
    set_mode(0);
    meas_rst = 1'b1;
    repeat (10) tick();
    meas_rst = 1'b0;
    repeat (50) tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL rmw_busy_before: got %b required 1", busy);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({resp, resp_mask, resp_valid, overrun, busy} !== 19'h0) begin
      errors++; $display("FAIL rmw_outputs_zero: got %h required 0", {resp, resp_mask, resp_valid, overrun, busy});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      checks++;
      if (busy !== 1'b0) begin
        errors++; $display("FAIL rmw_idle_low: cycle %0d busy=%b required 0", i, busy);
      end
    end
    meas_rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({busy, sat_valid} !== 2'b00) begin
        errors++; $display("FAIL rmw_no_bit: cycle %0d busy,sat_valid=%b required 00", i, {busy, sat_valid});
      end
    end
    meas_rst = 1'b0;
    repeat (100) tick();
    meas_rst = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL rmw_eval_busy: got %b required 1", busy);
    end
    tick();
    checks++;
    if ({sat_valid, dut.r_fill} !== 4'b1001) begin
      errors++; $display("FAIL rmw_first_bit: sat_valid,fill=%b required 1001", {sat_valid, dut.r_fill});
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    do_reset();
    sb.push_back({8'hFF, 8'hFF});
    sb.push_back({8'h55, 8'h55});
    for (int w = 0; w < 8; w++) window(0, 200);
    tick();
    exp = sb.pop_front();
    checks++;
    if ({resp_valid, resp, resp_mask} !== {1'b1, exp}) begin
      errors++; $display("FAIL b2b_first: got %h required %h", {resp_valid, resp, resp_mask}, {1'b1, exp});
    end
    for (int k = 0; k < 8; k++) window((k % 2 == 0) ? 0 : 1, 200);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    exp = sb.pop_front();
    checks++;
    if ({resp_valid, overrun} !== 2'b10) begin
      errors++; $display("FAIL b2b_flags: valid,overrun=%b required 10", {resp_valid, overrun});
    end
    checks++;
    if ({resp, resp_mask} !== exp) begin
      errors++; $display("FAIL b2b_second: got %h required %h", {resp, resp_mask}, exp);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp;
    sb_sat.push_back(2'b10);
    window(3, 100);
    checks++;
    if (dut_sat.u_cnt_a.o_cnt !== 4'd15) begin
      errors++; $display("FAIL sat_cnt_a: got %0d required 15", dut_sat.u_cnt_a.o_cnt);
    end
    tick();
    exp = sb_sat.pop_front();
    checks++;
    if ({sat_valid, sat_resp, sat_mask} !== {1'b1, exp}) begin
      errors++; $display("FAIL sat_word: valid,bit,mask=%b required %b", {sat_valid, sat_resp, sat_mask}, {1'b1, exp});
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    meas_rst   = 1'b1;
    resp_ready = 1'b0;
    test_reset();
    test_basic();
    test_near_tie();
    test_backpressure();
    test_reset_mid_window();
    test_back_to_back();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
